// File: rtl/dc_arb_pkg.sv
// Shared types and constants for the display-controller AXI read arbiter.
//   arb_mode_e     : arbitration policy (round-robin or fixed priority)
//   AXI_BURST_INCR : burst type driven on every AR
//   AXI_RESP_OKAY  : the only read response that is not flagged as an error
//   CNT_W          : width of the per-layer outstanding-burst counters
package dc_arb_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         CNT_W          = 4;

endpackage

// File: rtl/dc_rr_arbiter.sv
// Combinational request arbiter, one grant per evaluation.
//   i_req        : request vector, one bit per layer
//   i_last_grant : index granted most recently (round-robin pointer)
//   i_mode       : ARB_RR searches from i_last_grant+1, ARB_FIXED from index 0
//   o_grant      : one-hot grant (all zero when nothing requests)
//   o_idx        : encoded index of the granted layer (0 when no grant)
module dc_rr_arbiter
  import dc_arb_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int IDX_W      = 1
) (
  input  logic [NUM_LAYERS-1:0] i_req,
  input  logic [IDX_W-1:0]      i_last_grant,
  input  arb_mode_e             i_mode,
  output logic [NUM_LAYERS-1:0] o_grant,
  output logic [IDX_W-1:0]      o_idx
);

  // Search order: w_pos[0] is the first candidate examined.
  logic [IDX_W-1:0] w_pos [NUM_LAYERS];
  logic             w_found;

  always_comb begin
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (i_mode == ARB_FIXED) w_pos[k] = IDX_W'(k);
      else                     w_pos[k] = IDX_W'((int'(i_last_grant) + 1 + k) % NUM_LAYERS);
    end
  end

  // NOTE: every output gets a default before the search so no latch is inferred.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (!w_found && i_req[w_pos[k]]) begin
        w_found           = 1'b1;
        o_grant[w_pos[k]] = 1'b1;
        o_idx             = w_pos[k];
      end
    end
  end

endmodule

// File: rtl/dc_axi_read_arbiter.sv
// Shares one AXI read port among NUM_LAYERS layer fetch units.
// AR side: one registered holding slot, ARID carries the layer index, and
// each layer is limited to MAX_OUTSTANDING bursts in flight.
// R side: zero-latency demux by RID; unknown RIDs are sunk and flagged.
//   clk, rst       : clock, asynchronous active-high reset
//   en             : blocks new grants when low (held AR and R traffic continue)
//   arb_mode       : 0 round-robin, 1 fixed priority (layer 0 highest)
//   err_clear      : clears err_sticky (a same-cycle set wins)
//   s_ar*, s_r*    : per-layer slave-side AR / R channels
//   m_ar*, m_r*    : single master-side AR / R channels
//   err_sticky     : bit i = error response for layer i, top bit = spurious RID
//   idle           : no AR held and no bursts outstanding
module dc_axi_read_arbiter
  import dc_arb_pkg::*;
#(
  parameter int NUM_LAYERS       = 2,
  parameter int AXI_ARADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH   = 16,
  parameter int ID_WIDTH         = 8,
  parameter int MAX_OUTSTANDING  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   arb_mode,
  input  logic                                   err_clear,
  input  logic [NUM_LAYERS-1:0]                  s_arvalid,
  output logic [NUM_LAYERS-1:0]                  s_arready,
  input  logic [NUM_LAYERS*AXI_ARADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_LAYERS*8-1:0]                s_arlen,
  input  logic [NUM_LAYERS*3-1:0]                s_arsize,
  output logic [NUM_LAYERS-1:0]                  s_rvalid,
  input  logic [NUM_LAYERS-1:0]                  s_rready,
  output logic [AXI_DATA_WIDTH-1:0]              s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rlast,
  output logic [ID_WIDTH-1:0]                    m_arid,
  output logic [AXI_ARADDR_WIDTH-1:0]            m_araddr,
  output logic [7:0]                             m_arlen,
  output logic [2:0]                             m_arsize,
  output logic [1:0]                             m_arburst,
  output logic                                   m_arvalid,
  input  logic                                   m_arready,
  input  logic [ID_WIDTH-1:0]                    m_rid,
  input  logic [AXI_DATA_WIDTH-1:0]              m_rdata,
  input  logic [1:0]                             m_rresp,
  input  logic                                   m_rlast,
  input  logic                                   m_rvalid,
  output logic                                   m_rready,
  output logic [NUM_LAYERS:0]                    err_sticky,
  output logic                                   idle
);

  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [ID_WIDTH-1:0]         r_arid;
  logic [AXI_ARADDR_WIDTH-1:0] r_araddr;
  logic [7:0]                  r_arlen;
  logic [2:0]                  r_arsize;
  logic                        r_arvalid;
  logic [IDX_W-1:0]            r_last_grant;
  logic [CNT_W-1:0]            r_cnt [NUM_LAYERS];
  logic [NUM_LAYERS:0]         r_err;

  logic                        w_slot_free;
  logic [NUM_LAYERS-1:0]       w_elig;
  logic [NUM_LAYERS-1:0]       w_grant;
  logic [IDX_W-1:0]            w_idx;
  logic                        w_rid_ok;
  logic [IDX_W-1:0]            w_rsel;
  logic                        w_r_hs;
  logic [NUM_LAYERS-1:0]       w_dec;
  logic [NUM_LAYERS-1:0]       w_cnt_nz;
  logic [NUM_LAYERS:0]         w_err_set;

  // The slot can take a new AR in the same cycle the held one is accepted.
  assign w_slot_free = !r_arvalid || m_arready;

  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_elig[i]   = s_arvalid[i] && en && w_slot_free && !rst &&
                    (r_cnt[i] < CNT_W'(MAX_OUTSTANDING));
      w_cnt_nz[i] = |r_cnt[i];
    end
  end

  dc_rr_arbiter #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_arb (
    .i_req        (w_elig),
    .i_last_grant (r_last_grant),
    .i_mode       (arb_mode_e'(arb_mode)),
    .o_grant      (w_grant),
    .o_idx        (w_idx)
  );

  // A grant is only given to a valid requester, so it is the AR handshake.
  assign s_arready = w_grant;

  // R demux: RIDs outside the layer range are accepted and dropped.
  assign w_rid_ok = m_rid < ID_WIDTH'(NUM_LAYERS);
  assign w_rsel   = m_rid[IDX_W-1:0];
  assign w_r_hs   = m_rvalid && m_rready;

  always_comb begin
    s_rvalid  = '0;
    m_rready  = 1'b0;
    w_dec     = '0;
    w_err_set = '0;
    if (!rst) begin
      if (w_rid_ok) begin
        s_rvalid[w_rsel] = m_rvalid;
        m_rready         = s_rready[w_rsel];
      end else begin
        m_rready = 1'b1;
      end
    end
    if (w_r_hs) begin
      if (w_rid_ok) begin
        w_dec[w_rsel]     = m_rlast;
        w_err_set[w_rsel] = (m_rresp != AXI_RESP_OKAY);
      end else begin
        w_err_set[NUM_LAYERS] = 1'b1;
      end
    end
  end

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arvalid    <= 1'b0;
      r_arid       <= '0;
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arsize     <= '0;
      r_last_grant <= IDX_W'(NUM_LAYERS - 1);
    end else begin
      if (r_arvalid && m_arready) r_arvalid <= 1'b0;
      if (|w_grant) begin
        r_arvalid    <= 1'b1;
        r_arid       <= ID_WIDTH'(w_idx);
        r_araddr     <= s_araddr[w_idx*AXI_ARADDR_WIDTH +: AXI_ARADDR_WIDTH];
        r_arlen      <= s_arlen[w_idx*8 +: 8];
        r_arsize     <= s_arsize[w_idx*3 +: 3];
        r_last_grant <= w_idx;
      end
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it is reset
  // with everything else; a stale count would permanently throttle a layer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) r_cnt[i] <= '0;
      r_err <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (w_grant[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_grant[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      r_err <= (r_err & ~{(NUM_LAYERS + 1){err_clear}}) | w_err_set;
    end
  end

  assign m_arvalid  = r_arvalid;
  assign m_arid     = r_arid;
  assign m_araddr   = r_araddr;
  assign m_arlen    = r_arlen;
  assign m_arsize   = r_arsize;
  assign m_arburst  = AXI_BURST_INCR;
  assign err_sticky = r_err;
  assign idle       = !r_arvalid && (w_cnt_nz == '0);

endmodule
